// File: rtl/scan_display_ctrl_pkg.sv
// Shared definitions for the multiplexed 4-digit scoreboard driver:
// anode constants, slot phase encoding, display word record and blanking helper.
package scan_display_ctrl_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] ANODES_OFF = 4'b1111;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        lzb;
  } disp_word_t;

  // Digit i (i>0) is blanked when lzb is set and nibbles i..3 are all zero;
  // digit 0 always stays lit so an all-zero word still shows "0".
  function automatic logic [NUM_DIGITS-1:0] lzb_mask(input disp_word_t w);
    logic [NUM_DIGITS-1:0] m;
    logic                  upper_zero;
    m          = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero && (w.value[i*4 +: 4] == 4'h0);
      m[i]       = w.lzb && upper_zero;
    end
    return m;
  endfunction

endpackage

// File: rtl/scan_display_ctrl_slot_timer.sv
// Per-digit slot counter: runs 0..SCAN_DIV-1 and flags the last blanking
// cycle and the last cycle of the slot. Synchronous clear holds it at zero.
module slot_timer #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic blank_end,
  output logic slot_end
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] count_q;

  assign blank_end = (count_q == CW'(BLANK_CYC - 1));
  assign slot_end  = (count_q == CW'(SCAN_DIV - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count_q <= '0;
    end else if (slot_end) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/scan_display_ctrl.sv
// Time-multiplexed PMC14495 driver for a 4-digit common-anode scoreboard with
// dead-time blanking and a frame-synchronous double-buffered load port.
module scan_display_ctrl
  import scan_display_ctrl_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_value,
  input  logic [3:0]  load_dp,
  input  logic        load_lzb,
  output logic [3:0]  dec_d,
  output logic        dec_point,
  output logic        dec_le,
  output logic [3:0]  an,
  output logic        frame_tick
);

  state_t     state_q, state_d;
  logic [1:0] digit_q, digit_d;
  logic       blank_end, slot_end, timer_clr;
  logic       boundary, show, accept, cur_blank;
  logic [NUM_DIGITS-1:0] blank_mask;
  disp_word_t active_q, pend_q, load_word;
  logic       pend_empty_q;

  assign timer_clr = !en;

  slot_timer #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_slot_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (timer_clr),
    .blank_end (blank_end),
    .slot_end  (slot_end)
  );

  // NOTE: defaults come first so every path assigns state_d/digit_d and no
  // latch is inferred.
  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    if (!en) begin
      state_d = ST_BLANK;
    end else begin
      case (state_q)
        ST_BLANK: if (blank_end) state_d = ST_SHOW;
        ST_SHOW: if (slot_end) begin
          state_d = ST_BLANK;
          digit_d = digit_q + 2'd1;
        end
        default: state_d = ST_BLANK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_BLANK;
      digit_q <= '0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
    end
  end

  assign boundary  = en && (state_q == ST_SHOW) && slot_end && (digit_q == 2'd3);
  assign accept    = load_valid && pend_empty_q;
  assign load_word = {load_value, load_dp, load_lzb};

  // Pending drains only at a frame boundary so a frame never mixes two words;
  // while dark there is nothing to tear, so it drains immediately.
  // NOTE: both buffers carry an explicit reset value because the display
  // contents after reset are architecturally visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q     <= '0;
      pend_q       <= '0;
      pend_empty_q <= 1'b1;
    end else if ((boundary || !en) && !pend_empty_q) begin
      active_q     <= pend_q;
      pend_empty_q <= 1'b1;
    end else if (accept && boundary) begin
      active_q     <= load_word;
    end else if (accept) begin
      pend_q       <= load_word;
      pend_empty_q <= 1'b0;
    end
  end

  assign load_ready = pend_empty_q;

  assign blank_mask = lzb_mask(active_q);
  assign cur_blank  = blank_mask[digit_q];
  assign show       = en && (state_q == ST_SHOW);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an         <= ANODES_OFF;
      dec_d      <= '0;
      dec_point  <= 1'b0;
      dec_le     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      an         <= (show && !cur_blank) ? ~(4'b0001 << digit_q) : ANODES_OFF;
      dec_d      <= active_q.value[{digit_q, 2'b00} +: 4];
      dec_point  <= active_q.dp[digit_q] && !(show && cur_blank);
      dec_le     <= show;
      frame_tick <= boundary;
    end
  end

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Self-checking bench for scan_display_ctrl: per-cycle reference model,
// table-driven frame captures, hand-written corner sequences, random soak.
module tb_scan_display_ctrl;

  localparam int SD = 16;
  localparam int BC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_value = '0;
  logic [3:0]  load_dp = '0;
  logic        load_lzb = 1'b0;
  logic [3:0]  dec_d;
  logic        dec_point;
  logic        dec_le;
  logic [3:0]  an;
  logic        frame_tick;

  always #5 clk = ~clk;

  scan_display_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .load_dp    (load_dp),
    .load_lzb   (load_lzb),
    .dec_d      (dec_d),
    .dec_point  (dec_point),
    .dec_le     (dec_le),
    .an         (an),
    .frame_tick (frame_tick)
  );

  int checks   = 0;
  int failures = 0;
  int cycle_no = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cycle_no, act, exp);
    end
  endtask

  // Reference model: slot position / digit as integers, buffers as plain words.
  int          m_pos, m_digit;
  logic [15:0] m_active, m_pend;
  logic [3:0]  m_adp, m_pdp;
  logic        m_alzb, m_plzb, m_pfull;
  logic [3:0]  e_an, e_d;
  logic        e_dp, e_le, e_tick, e_ready;

  task automatic model_edge();
    bit         show, blk, boundary, accept;
    logic [3:0] one_hot;
    if (!rst_n) begin
      m_pos = 0; m_digit = 0;
      m_active = '0; m_pend = '0; m_adp = '0; m_pdp = '0;
      m_alzb = 0; m_plzb = 0; m_pfull = 0;
      e_an = 4'hF; e_d = 4'h0; e_dp = 0; e_le = 0; e_tick = 0; e_ready = 1;
      return;
    end
    show    = en && (m_pos >= BC);
    blk     = m_alzb && (m_digit != 0) && ((m_active >> (4 * m_digit)) == 16'h0);
    one_hot = 4'(1 << m_digit);
    e_an    = (show && !blk) ? ~one_hot : 4'hF;
    e_d     = 4'((m_active >> (4 * m_digit)) & 16'hF);
    e_dp    = m_adp[m_digit] && !(show && blk);
    e_le    = show;
    e_tick  = en && (m_pos == SD - 1) && (m_digit == 3);
    boundary = e_tick;
    accept   = load_valid && !m_pfull;
    if ((boundary || !en) && m_pfull) begin
      m_active = m_pend; m_adp = m_pdp; m_alzb = m_plzb; m_pfull = 0;
    end else if (accept && boundary) begin
      m_active = load_value; m_adp = load_dp; m_alzb = load_lzb;
    end else if (accept) begin
      m_pend = load_value; m_pdp = load_dp; m_plzb = load_lzb; m_pfull = 1;
    end
    e_ready = !m_pfull;
    if (!en) begin
      m_pos = 0;
    end else if (m_pos == SD - 1) begin
      m_pos = 0;
      m_digit = (m_digit + 1) % 4;
    end else begin
      m_pos++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cycle_no++;
    check("an", an, e_an);
    check("dec_d", dec_d, e_d);
    check("dec_point", dec_point, e_dp);
    check("dec_le", dec_le, e_le);
    check("frame_tick", frame_tick, e_tick);
    check("load_ready", load_ready, e_ready);
  endtask

  task automatic wait_an(input logic [3:0] target, input int budget, output int n);
    n = 0;
    while (an !== target && n < budget) begin
      step();
      n++;
    end
    check("wait_an_reached", an, target);
  endtask

  task automatic load_word(input logic [15:0] v, input logic [3:0] dp, input logic lzb);
    int n = 0;
    while (load_ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check("load_ready_wait", load_ready, 1'b1);
    load_value = v; load_dp = dp; load_lzb = lzb; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
  endtask

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        lzb;
    logic [3:0]  lit;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int          n;
    int          tick_at;
    logic [3:0]  seen;
    logic [3:0]  seen_nib[4];
    logic        seen_dp[4];
    int          lit_cnt[4];
    logic [15:0] v;
    logic [3:0]  ohot;

    tbl[0] = '{16'h1A2F, 4'b0100, 1'b0, 4'b1111};
    tbl[1] = '{16'h0005, 4'b0000, 1'b1, 4'b0001};
    tbl[2] = '{16'h0000, 4'b0001, 1'b1, 4'b0001};
    tbl[3] = '{16'h0100, 4'b1010, 1'b1, 4'b0111};
    tbl[4] = '{16'h0100, 4'b0000, 1'b0, 4'b1111};
    tbl[5] = '{16'h00F0, 4'b1111, 1'b1, 4'b0011};

    // Reset and first SHOW latency.
    rst_n = 1'b0;
    step(); step();
    check("rst_an", an, 4'hF);
    check("rst_le", dec_le, 1'b0);
    check("rst_ready", load_ready, 1'b1);
    rst_n = 1'b1;
    en    = 1'b1;
    wait_an(4'b1110, 50, n);
    check("first_show_cycle", n, 5);

    // Table-driven frame captures.
    for (int k = 0; k < 6; k++) begin
      load_word(tbl[k].value, tbl[k].dp, tbl[k].lzb);
      n = 0;
      while (frame_tick !== 1'b1 && n < 200) begin
        step();
        n++;
      end
      check("frame_tick_seen", frame_tick, 1'b1);
      seen = '0;
      tick_at = 0;
      for (int i = 0; i < 4; i++) begin
        lit_cnt[i] = 0; seen_nib[i] = 4'h0; seen_dp[i] = 1'b0;
      end
      for (int c = 1; c <= 4 * SD; c++) begin
        step();
        if (frame_tick === 1'b1) tick_at = c;
        for (int i = 0; i < 4; i++) begin
          ohot = 4'(1 << i);
          if (an === ~ohot) begin
            seen[i] = 1'b1;
            lit_cnt[i]++;
            seen_nib[i] = dec_d;
            seen_dp[i] = dec_point;
          end
        end
      end
      check("tbl_lit_mask", seen, tbl[k].lit);
      check("tbl_frame_period", tick_at, 4 * SD);
      v = tbl[k].value;
      for (int i = 0; i < 4; i++) begin
        if (tbl[k].lit[i]) begin
          check("tbl_nibble", seen_nib[i], v[4*i +: 4]);
          check("tbl_dp", seen_dp[i], tbl[k].dp[i]);
          check("tbl_show_len", lit_cnt[i], SD - BC);
        end
      end
    end

    // Mid-frame double load: second word waits for the frame boundary.
    wait_an(4'b1101, 200, n);
    load_value = 16'h1234; load_dp = 4'b0001; load_lzb = 1'b0; load_valid = 1'b1;
    step();
    check("ready_falls", load_ready, 1'b0);
    load_value = 16'h5678; load_dp = 4'b1000;
    n = 0;
    while (load_ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check("ready_returns", load_ready, 1'b1);
    check("ready_with_tick", frame_tick, 1'b1);
    step();
    load_valid = 1'b0;
    for (int c = 0; c < 150; c++) step();

    // en dropped during digit 2 SHOW.
    wait_an(4'b1011, 200, n);
    en = 1'b0;
    step();
    check("en_off_dark", an, 4'hF);
    check("en_off_le", dec_le, 1'b0);
    step(); step(); step();
    en = 1'b1;
    wait_an(4'b1011, 50, n);
    check("en_resume_latency", n, BC + 1);

    // Reset in digit 3 with a pending word.
    wait_an(4'b0111, 200, n);
    load_value = 16'h9ABC; load_dp = 4'b1111; load_lzb = 1'b0; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    check("pending_held", load_ready, 1'b0);
    rst_n = 1'b0;
    step();
    check("midrst_an", an, 4'hF);
    check("midrst_ready", load_ready, 1'b1);
    check("midrst_dec_d", dec_d, 4'h0);
    rst_n = 1'b1;
    wait_an(4'b1110, 50, n);
    check("midrst_restart", n, BC + 1);
    for (int c = 0; c < 70; c++) step();

    // Random soak against the model.
    for (int c = 0; c < 1200; c++) begin
      en         = ($urandom_range(0, 15) != 0);
      load_valid = ($urandom_range(0, 3) == 0);
      load_value = 16'($urandom) >> (4 * $urandom_range(0, 3));
      load_dp    = 4'($urandom);
      load_lzb   = 1'($urandom);
      rst_n      = ($urandom_range(0, 499) != 0);
      step();
    end
    rst_n = 1'b1;
    load_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
